ram_burst_ctrl: RTL

Initiator-side burst controller that drives a single-port synchronous RAM (DEPTH x WIDTH, write when w_en is high, registered read data valid the cycle after a non-write address).
- Accepts a read or write burst command from a host over a valid/ready handshake.
- Write bursts stream data in; read bursts stream data out, with full backpressure on both streams.
- Sits between the datapath/host logic and the RAM instance, and owns all RAM port signals.

---
 rtl/ram_burst_ctrl_pkg.sv | 15 +
 rtl/ram_burst_ctrl_rd_skid_fifo.sv | 51 +++++
 rtl/ram_burst_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ram_burst_ctrl_pkg.sv
// Shared types and constants for the RAM burst controller.
//   state_t    : controller FSM states
//   FIFO_DEPTH : entries in the read-side skid FIFO
package ram_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_burst_ctrl_rd_skid_fifo.sv
// Two-entry read skid FIFO with a registered head word.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write a word (legal with pop when count is 1 or 2)
//   pop        : discard the head word (only when count != 0)
//   count      : number of stored words, 0..2
//   head       : oldest stored word; holds while not popped
module rd_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // count stays the same; the new word lands behind whatever remains
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Initiator-side burst controller for a single-port synchronous RAM.
//   cmd_*      : host burst command (valid/ready), write flag, start address, length
//   wr_*       : write data stream into the RAM (valid/ready)
//   rd_*       : read data stream out of the RAM (valid/ready)
//   busy, done : activity flag and one-cycle completion pulse
//   ram_*      : RAM port (write enable, address, write data, registered read data)
module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [AW:0]      cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             ram_w_en,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  state_t        state, state_nx;
  logic [AW-1:0] cur_addr, addr_inc, ram_addr_q;
  logic [AW:0]   remaining;
  logic          inflight;
  logic [1:0]    fifo_count;
  logic          pop, beat, issue;
  logic [2:0]    occupancy;

  // explicit wrap so non-power-of-two depths work
  assign addr_inc = (cur_addr == AW'(DEPTH - 1)) ? '0 : cur_addr + 1'b1;

  assign pop  = rd_valid && rd_ready;
  assign beat = (state == WRITE) && wr_valid;

  // words that will be buffered once this cycle's pop and the RAM word in flight settle
  assign occupancy = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight};
  assign issue     = (state == READ) && (remaining != '0) && (occupancy < 3'(FIFO_DEPTH));

  assign rd_valid = (fifo_count != 2'd0);

  rd_skid_fifo #(.WIDTH(WIDTH)) u_rd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (ram_rdata),
    .pop   (pop),
    .count (fifo_count),
    .head  (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      inflight   <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (state == IDLE && cmd_valid) begin
        cur_addr  <= cmd_addr;
        remaining <= cmd_len;
      end else if (beat || issue) begin
        cur_addr  <= addr_inc;
        remaining <= remaining - 1'b1;
      end
      if (state == WRITE || state == READ) ram_addr_q <= cur_addr;
    end
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    ram_w_en  = 1'b0;
    ram_addr  = ram_addr_q;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0) state_nx = DONE;
          else               state_nx = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready  = 1'b1;
        ram_w_en  = wr_valid;
        ram_addr  = cur_addr;
        ram_wdata = wr_data;
        if (wr_valid && remaining == (AW+1)'(1)) state_nx = DONE;
      end
      READ: begin
        ram_addr = cur_addr;
        if (remaining == '0 && !inflight && (occupancy == 3'd0)) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
